// File: rtl/cache_assoc.sv
// cache_assoc: set-associative, write-through, no-write-allocate cache between a requester and
// the memory arbiter. Round-robin replacement per set, whole-cache flush, hit/miss counters.
//
// Ports:
//   clk, rst                    clock and synchronous active-high reset
//   enable, wr_en, data_in,     request strobe (sampled in idle), store flag, store data
//   data_size, addr, flush      (right-aligned), size code, byte address, invalidate-all
//   data_out                    load result, zero-extended, holds across stores
//   operation_complete          one-cycle done pulse
//   mem_address, mem_data_out,  arbiter request: address, store data, size, write flag,
//   mem_data_size, mem_wr_en,   one-cycle request pulse
//   mem_req
//   mem_data_in, mem_data_valid refill line, refill valid / write acknowledge
//   hit_count, miss_count       wrapping perf counters of completed requests
module cache_assoc #(
  parameter int unsigned BLOCKSZ     = 512,
  parameter int unsigned WIDTH       = 64,
  parameter int unsigned NUMSETS     = 256,
  parameter int unsigned WAYS        = 2,
  parameter int unsigned ADDRESSSIZE = 64,
  parameter int unsigned CNTWIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       data_in,
  input  logic [2:0]             data_size,
  input  logic [ADDRESSSIZE-1:0] addr,
  input  logic                   flush,
  output logic [WIDTH-1:0]       data_out,
  output logic                   operation_complete,
  output logic [ADDRESSSIZE-1:0] mem_address,
  output logic [WIDTH-1:0]       mem_data_out,
  output logic [2:0]             mem_data_size,
  output logic                   mem_wr_en,
  output logic                   mem_req,
  input  logic [BLOCKSZ-1:0]     mem_data_in,
  input  logic                   mem_data_valid,
  output logic [CNTWIDTH-1:0]    hit_count,
  output logic [CNTWIDTH-1:0]    miss_count
);

  localparam int unsigned OFFWIDTH  = $clog2(BLOCKSZ / 8);
  localparam int unsigned IDXWIDTH  = $clog2(NUMSETS);
  localparam int unsigned TAGWIDTH  = ADDRESSSIZE - IDXWIDTH - OFFWIDTH;
  localparam int unsigned WAYBITS   = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int unsigned WORDBYTES = WIDTH / 8;

  typedef enum logic [2:0] {StIdle, StLookup, StRefillWait, StWriteWait, StRespond} state_e;
  state_e state_q, state_d;

  // Latched request
  logic [ADDRESSSIZE-1:0] req_addr_q;
  logic                   req_wr_q;
  logic [WIDTH-1:0]       req_data_q;
  logic [2:0]             req_size_q;
  logic                   hit_q;

  // Storage
  logic [BLOCKSZ-1:0]  data_mem [WAYS][NUMSETS];
  logic [TAGWIDTH-1:0] tag_mem  [WAYS][NUMSETS];
  logic [NUMSETS-1:0]  valid_q  [WAYS];
  logic [WAYBITS-1:0]  rr_q     [NUMSETS];

  logic [TAGWIDTH-1:0] req_tag;
  logic [IDXWIDTH-1:0] req_set;
  logic [OFFWIDTH-1:0] req_off;

  assign req_tag = req_addr_q[ADDRESSSIZE-1 -: TAGWIDTH];
  assign req_set = req_addr_q[OFFWIDTH +: IDXWIDTH];
  assign req_off = req_addr_q[OFFWIDTH-1:0];

  // A write acknowledge or refill is only meaningful once the request pulse has gone out.
  logic mem_ack;
  assign mem_ack = mem_data_valid & ~mem_req;

  assign operation_complete = (state_q == StRespond);

  // Tag compare
  logic [WAYS-1:0]    hit_vec;
  logic               hit_any;
  logic [WAYBITS-1:0] hit_way;
  logic [BLOCKSZ-1:0] hit_line;

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[w][req_set] && (tag_mem[w][req_set] == req_tag);
      if (hit_vec[w]) hit_way = WAYBITS'(w);
    end
  end

  assign hit_any  = |hit_vec;
  assign hit_line = data_mem[hit_way][req_set];

  // Victim: lowest invalid way, else the set's round-robin pointer
  logic               all_valid;
  logic [WAYBITS-1:0] victim;
  logic [WAYBITS-1:0] rr_next;

  always_comb begin
    all_valid = 1'b1;
    victim    = rr_q[req_set];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][req_set]) begin
        all_valid = 1'b0;
        victim    = WAYBITS'(w);
      end
    end
  end

  assign rr_next = (rr_q[req_set] == WAYBITS'(WAYS - 1)) ? '0 : rr_q[req_set] + 1'b1;

  // Sub-word store merge into the hit line
  logic [WIDTH-1:0]   byte_mask_w;
  logic [BLOCKSZ-1:0] store_data_line;
  logic [BLOCKSZ-1:0] store_mask_line;
  logic [BLOCKSZ-1:0] merged_line;

  always_comb begin
    byte_mask_w = '0;
    for (int i = 0; i < WORDBYTES; i++) begin
      if (i < (1 << req_size_q)) byte_mask_w[8*i +: 8] = 8'hff;
    end
    store_data_line = {{(BLOCKSZ - WIDTH){1'b0}}, req_data_q} << {req_off, 3'b000};
    store_mask_line = {{(BLOCKSZ - WIDTH){1'b0}}, byte_mask_w} << {req_off, 3'b000};
    merged_line     = (hit_line & ~store_mask_line) | (store_data_line & store_mask_line);
  end

  // Pick 2^size bytes at the offset and zero-extend
  function automatic logic [WIDTH-1:0] extract(input logic [BLOCKSZ-1:0] line,
                                               input logic [OFFWIDTH-1:0] off,
                                               input logic [2:0]          size);
    logic [BLOCKSZ-1:0] sh;
    logic [WIDTH-1:0]   r;
    sh = line >> {off, 3'b000};
    r  = sh[WIDTH-1:0];
    for (int i = 0; i < WORDBYTES; i++) begin
      if (i >= (1 << size)) r[8*i +: 8] = 8'h00;
    end
    return r;
  endfunction

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!flush && enable) state_d = StLookup;
      end
      StLookup: begin
        if (req_wr_q)     state_d = StWriteWait;
        else if (hit_any) state_d = StRespond;
        else              state_d = StRefillWait;
      end
      StRefillWait: if (mem_ack) state_d = StRespond;
      StWriteWait:  if (mem_ack) state_d = StRespond;
      StRespond:    state_d = StIdle;
      default:      state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Control, request registers, valid bits, pointers, counters
  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr_q    <= '0;
      req_wr_q      <= 1'b0;
      req_data_q    <= '0;
      req_size_q    <= '0;
      hit_q         <= 1'b0;
      data_out      <= '0;
      mem_req       <= 1'b0;
      mem_wr_en     <= 1'b0;
      mem_address   <= '0;
      mem_data_out  <= '0;
      mem_data_size <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      for (int s = 0; s < NUMSETS; s++) rr_q[s] <= '0;
    end else begin
      mem_req <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (flush) begin
            for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
          end else if (enable) begin
            req_addr_q <= addr;
            req_wr_q   <= wr_en;
            req_data_q <= data_in;
            req_size_q <= data_size;
          end
        end
        StLookup: begin
          hit_q <= hit_any;
          if (req_wr_q) begin
            mem_req       <= 1'b1;
            mem_wr_en     <= 1'b1;
            mem_address   <= req_addr_q;
            mem_data_out  <= req_data_q;
            mem_data_size <= req_size_q;
          end else if (hit_any) begin
            data_out <= extract(hit_line, req_off, req_size_q);
          end else begin
            mem_req       <= 1'b1;
            mem_wr_en     <= 1'b0;
            mem_address   <= {req_addr_q[ADDRESSSIZE-1:OFFWIDTH], {OFFWIDTH{1'b0}}};
            mem_data_size <= req_size_q;
          end
        end
        StRefillWait: begin
          if (mem_ack) begin
            valid_q[victim][req_set] <= 1'b1;
            if (all_valid) rr_q[req_set] <= rr_next;
            data_out <= extract(mem_data_in, req_off, req_size_q);
          end
        end
        StRespond: begin
          if (hit_q) hit_count  <= hit_count + 1'b1;
          else       miss_count <= miss_count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Line and tag arrays carry no reset; the valid bits gate their use.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == StLookup && req_wr_q && hit_any) begin
        data_mem[hit_way][req_set] <= merged_line;
      end
      if (state_q == StRefillWait && mem_ack) begin
        data_mem[victim][req_set] <= mem_data_in;
        tag_mem[victim][req_set]  <= req_tag;
      end
    end
  end

  // Tags in a set must be unique among valid ways
  a_onehot_hit: assert property (@(posedge clk) disable iff (rst)
                                 (state_q == StLookup) |-> $onehot0(hit_vec));

endmodule

// File: tb/tb_cache_assoc.sv
// Self-checking bench for cache_assoc with default parameters. A byte-addressed memory model
// backs the arbiter side; expected load results are queued at issue and compared on completion.
module tb_cache_assoc;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic         wr_en;
  logic [63:0]  data_in;
  logic [2:0]   data_size;
  logic [63:0]  addr;
  logic         flush;
  logic [63:0]  data_out;
  logic         operation_complete;
  logic [63:0]  mem_address;
  logic [63:0]  mem_data_out;
  logic [2:0]   mem_data_size;
  logic         mem_wr_en;
  logic         mem_req;
  logic [511:0] mem_data_in;
  logic         mem_data_valid;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  logic [63:0] last_out = '0;
  logic [63:0] exp_q[$];
  logic [511:0] mem_lines [logic [63:0]];

  cache_assoc dut (
    .clk                (clk),
    .rst                (rst),
    .enable             (enable),
    .wr_en              (wr_en),
    .data_in            (data_in),
    .data_size          (data_size),
    .addr               (addr),
    .flush              (flush),
    .data_out           (data_out),
    .operation_complete (operation_complete),
    .mem_address        (mem_address),
    .mem_data_out       (mem_data_out),
    .mem_data_size      (mem_data_size),
    .mem_wr_en          (mem_wr_en),
    .mem_req            (mem_req),
    .mem_data_in        (mem_data_in),
    .mem_data_valid     (mem_data_valid),
    .hit_count          (hit_count),
    .miss_count         (miss_count)
  );

  always #5 clk = ~clk;

  function automatic logic [511:0] gen_line(input logic [63:0] base);
    logic [511:0] l;
    for (int k = 0; k < 8; k++) l[64*k +: 64] = (64'h1111_2222_3333_4444 * 64'(k + 1)) ^ base;
    return l;
  endfunction

  function automatic logic [511:0] get_line(input logic [63:0] base);
    if (!mem_lines.exists(base)) mem_lines[base] = gen_line(base);
    return mem_lines[base];
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] a, input logic [2:0] size);
    logic [511:0] l;
    logic [63:0]  r;
    int           off;
    l   = get_line({a[63:6], 6'b0});
    off = int'(a[5:0]);
    r   = '0;
    for (int i = 0; i < (1 << size); i++) r[8*i +: 8] = l[8*(off + i) +: 8];
    return r;
  endfunction

  function automatic void model_store(input logic [63:0] a, input logic [2:0] size,
                                      input logic [63:0] d);
    logic [511:0] l;
    logic [63:0]  base;
    int           off;
    base = {a[63:6], 6'b0};
    l    = get_line(base);
    off  = int'(a[5:0]);
    for (int i = 0; i < (1 << size); i++) l[8*(off + i) +: 8] = d[8*i +: 8];
    mem_lines[base] = l;
  endfunction

  // Scoreboard: every completion must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && operation_complete === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_complete: operation_complete=1 expected 0");
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          errors++;
          $display("FAIL data_out: got %h expected %h", data_out, e);
        end
      end
    end
  end

  // One request from a negedge in idle; returns at a negedge in idle with counters checked.
  task automatic do_req(input string name, input logic wr, input logic [2:0] size,
                        input logic [63:0] a, input logic [63:0] d, input logic exp_hit,
                        input int lat);
    logic [63:0] base;
    logic [63:0] exp_addr;
    logic [63:0] exp_data;
    base     = {a[63:6], 6'b0};
    exp_addr = wr ? a : base;
    exp_data = wr ? last_out : model_load(a, size);
    exp_q.push_back(exp_data);
    last_out  = exp_data;
    enable    = 1'b1;
    wr_en     = wr;
    data_in   = d;
    data_size = size;
    addr      = a;
    @(negedge clk);
    enable = 1'b0;
    checks++;
    if (mem_req !== 1'b0) begin
      errors++; $display("FAIL %s lookup_mem_req: got %b expected 0", name, mem_req);
    end
    @(negedge clk);
    if (!wr && exp_hit) begin
      checks++;
      if (operation_complete !== 1'b1) begin
        errors++; $display("FAIL %s hit_latency: complete=%b expected 1", name, operation_complete);
      end
      checks++;
      if (mem_req !== 1'b0) begin
        errors++; $display("FAIL %s hit_mem_req: got %b expected 0", name, mem_req);
      end
    end else begin
      checks++;
      if (mem_req !== 1'b1) begin
        errors++; $display("FAIL %s mem_req: got %b expected 1", name, mem_req);
      end
      checks++;
      if (mem_address !== exp_addr) begin
        errors++; $display("FAIL %s mem_address: got %h expected %h", name, mem_address, exp_addr);
      end
      checks++;
      if (mem_wr_en !== wr) begin
        errors++; $display("FAIL %s mem_wr_en: got %b expected %b", name, mem_wr_en, wr);
      end
      checks++;
      if (mem_data_size !== size) begin
        errors++; $display("FAIL %s mem_data_size: got %0d expected %0d", name, mem_data_size, size);
      end
      if (wr) begin
        checks++;
        if (mem_data_out !== d) begin
          errors++; $display("FAIL %s mem_data_out: got %h expected %h", name, mem_data_out, d);
        end
      end
      repeat (lat) @(negedge clk);
      checks++;
      if (mem_address !== exp_addr) begin
        errors++; $display("FAIL %s addr_stable: got %h expected %h", name, mem_address, exp_addr);
      end
      if (wr) begin
        model_store(a, size, d);
        mem_data_in = {16{32'hBAD0_BAD0}};
      end else begin
        mem_data_in = get_line(base);
      end
      mem_data_valid = 1'b1;
      @(negedge clk);
      mem_data_valid = 1'b0;
      checks++;
      if (operation_complete !== 1'b1) begin
        errors++; $display("FAIL %s complete: got %b expected 1", name, operation_complete);
      end
    end
    @(negedge clk);
    if (exp_hit) exp_hits++;
    else exp_misses++;
    checks++;
    if (hit_count !== 32'(exp_hits)) begin
      errors++; $display("FAIL %s hit_count: got %0d expected %0d", name, hit_count, exp_hits);
    end
    checks++;
    if (miss_count !== 32'(exp_misses)) begin
      errors++; $display("FAIL %s miss_count: got %0d expected %0d", name, miss_count, exp_misses);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    enable = 1'b0; wr_en = 1'b0; data_in = '0; data_size = '0; addr = '0; flush = 1'b0;
    mem_data_in = '0; mem_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({data_out, mem_address, mem_data_out} !== '0) begin
      errors++; $display("FAIL reset_data: got %h %h %h expected 0", data_out, mem_address,
                         mem_data_out);
    end
    checks++;
    if ({operation_complete, mem_req, mem_wr_en, mem_data_size} !== '0) begin
      errors++; $display("FAIL reset_ctrl: got %b%b%b %0d expected 0", operation_complete,
                         mem_req, mem_wr_en, mem_data_size);
    end
    checks++;
    if ({hit_count, miss_count} !== '0) begin
      errors++; $display("FAIL reset_counts: got %0d %0d expected 0", hit_count, miss_count);
    end
  endtask

  task automatic test_cold_read;
    logic [511:0] l;
    l = gen_line(64'h1000);
    l[127:64] = 64'hDEAD_BEEF_CAFE_F00D;
    mem_lines[64'h1000] = l;
    do_req("cold", 1'b0, 3'd3, 64'h1008, 64'h0, 1'b0, 1);
    checks++;
    if (data_out !== 64'hDEAD_BEEF_CAFE_F00D) begin
      errors++; $display("FAIL cold_value: got %h expected deadbeefcafef00d", data_out);
    end
    do_req("rehit", 1'b0, 3'd3, 64'h1008, 64'h0, 1'b1, 1);
  endtask

  task automatic test_eviction;
    do_req("ev0", 1'b0, 3'd3, 64'h0000, 64'h0, 1'b0, 2);
    do_req("ev1", 1'b0, 3'd3, 64'h4000, 64'h0, 1'b0, 1);
    do_req("ev2", 1'b0, 3'd3, 64'h8000, 64'h0, 1'b0, 3);
    do_req("ev1_hit", 1'b0, 3'd3, 64'h4000, 64'h0, 1'b1, 1);
    do_req("ev0_miss", 1'b0, 3'd3, 64'h0000, 64'h0, 1'b0, 1);
  endtask

  task automatic test_subword_store;
    do_req("st_byte", 1'b1, 3'd0, 64'h1003, 64'hAB, 1'b1, 2);
    do_req("ld_word", 1'b0, 3'd2, 64'h1000, 64'h0, 1'b1, 1);
    checks++;
    if (data_out !== 64'h0000_0000_AB33_5444) begin
      errors++; $display("FAIL merged_word: got %h expected 00000000ab335444", data_out);
    end
  endtask

  task automatic test_store_miss;
    do_req("st_miss", 1'b1, 3'd3, 64'h2000, 64'h1122_3344_5566_7788, 1'b0, 1);
    do_req("ld_after", 1'b0, 3'd3, 64'h2000, 64'h0, 1'b0, 1);
    checks++;
    if (data_out !== 64'h1122_3344_5566_7788) begin
      errors++; $display("FAIL no_alloc_value: got %h expected 1122334455667788", data_out);
    end
  endtask

  task automatic test_flush;
    flush = 1'b1; enable = 1'b1; wr_en = 1'b0; data_size = 3'd3; addr = 64'h1000;
    @(negedge clk);
    flush = 1'b0; enable = 1'b0;
    mem_data_in = '1; mem_data_valid = 1'b1;  // stray valid while idle
    @(negedge clk);
    mem_data_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem_req !== 1'b0 || operation_complete !== 1'b0) begin
        errors++; $display("FAIL flush_quiet: req=%b complete=%b expected 0 0", mem_req,
                           operation_complete);
      end
      @(negedge clk);
    end
    do_req("post_flush", 1'b0, 3'd3, 64'h1000, 64'h0, 1'b0, 1);
  endtask

  task automatic test_reset_mid_refill;
    enable = 1'b1; wr_en = 1'b0; data_size = 3'd3; addr = 64'h3000;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL rst_setup_req: got %b expected 1", mem_req);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_data_in = get_line(64'h3000);
    mem_data_valid = 1'b1;
    @(negedge clk);
    mem_data_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (operation_complete !== 1'b0) begin
        errors++; $display("FAIL rst_no_complete: got %b expected 0", operation_complete);
      end
      @(negedge clk);
    end
    checks++;
    if ({data_out, mem_address, mem_data_out, hit_count, miss_count} !== '0 ||
        {operation_complete, mem_req, mem_wr_en, mem_data_size} !== '0) begin
      errors++; $display("FAIL rst_outputs: got %h %h %h %0d %0d expected 0", data_out,
                         mem_address, mem_data_out, hit_count, miss_count);
    end
    exp_hits = 0; exp_misses = 0; last_out = '0;
    do_req("rst_reload", 1'b0, 3'd3, 64'h3000, 64'h0, 1'b0, 1);
  endtask

  task automatic test_back_to_back;
    do_req("half", 1'b0, 3'd1, 64'h3006, 64'h0, 1'b1, 1);
    do_req("byte_top", 1'b0, 3'd0, 64'h303F, 64'h0, 1'b1, 1);
    do_req("word_miss", 1'b0, 3'd2, 64'h5024, 64'h0, 1'b0, 4);
    do_req("st_half", 1'b1, 3'd1, 64'h5022, 64'hFFFF_FFFF_FFFF_1234, 1'b1, 1);
    do_req("word_hit", 1'b0, 3'd2, 64'h5020, 64'h0, 1'b1, 1);
  endtask

  initial begin
    test_reset();
    test_cold_read();
    test_eviction();
    test_subword_store();
    test_store_miss();
    test_flush();
    test_reset_mid_refill();
    test_back_to_back();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL pending_completions: got %0d expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
